// File: rtl/uart.sv
// Full-duplex UART: one transmitter and one oversampling receiver sharing a baud-tick generator.
// Define UART_PARITY_EN to add an even-parity bit between the last data bit and the stop bit.
module uart #(
  parameter int DATA_SIZE   = 8,
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int OVERSAMPLE  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 TX_START,
  input  logic [DATA_SIZE-1:0] data_in,
  output logic                 tx_line,
  input  logic                 rx_line,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 tx_busy,
  output logic                 rx_done,
  output logic                 rx_frame_err,
  output logic [1:0]           tx_state,
  output logic [1:0]           rx_state
);

  localparam int DIV_RAW  = (CLK_FREQ_HZ + BAUD_RATE * OVERSAMPLE / 2) / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV      = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int BIT_CLKS = DIV * OVERSAMPLE;
`ifdef UART_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int FRAME_BITS = DATA_SIZE + PAR_BITS;

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CLK_W = $clog2(BIT_CLKS);
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [CLK_W-1:0] CLK_LAST = CLK_W'(BIT_CLKS - 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Oversample tick generator (receiver timing only)
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                div_cnt <= '0;
    else if (div_cnt == DIV_LAST) div_cnt <= '0;
    else                       div_cnt <= div_cnt + 1'b1;
  end

  // Transmitter. Handshake: TX_START is a level request; it is accepted on any
  // rising edge where the FSM is in IDLE (tx_busy=0) and ignored otherwise.
  state_t                tx_st;
  logic [CLK_W-1:0]      tx_cnt;
  logic [BIT_W-1:0]      tx_bit;
  logic [FRAME_BITS-1:0] tx_shift;
  logic [FRAME_BITS-1:0] tx_load;

`ifdef UART_PARITY_EN
  assign tx_load = {^data_in, data_in};
`else
  assign tx_load = data_in;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_st    <= IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      case (tx_st)
        IDLE: begin
          if (TX_START) begin
            tx_shift <= tx_load;
            tx_busy  <= 1'b1;
            tx_line  <= 1'b0;
            tx_cnt   <= '0;
            tx_st    <= START;
          end
        end
        START: begin
          if (tx_cnt == CLK_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_line  <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_st    <= DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        DATA: begin
          if (tx_cnt == CLK_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == BIT_LAST) begin
              tx_line <= 1'b1;
              tx_st   <= STOP;
            end else begin
              tx_bit   <= tx_bit + 1'b1;
              tx_line  <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        STOP: begin
          if (tx_cnt == CLK_LAST) begin
            tx_cnt  <= '0;
            tx_busy <= 1'b0;
            tx_st   <= IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_st <= IDLE;
      endcase
    end
  end

  // Receiver: 2-FF synchroniser resets to the idle (high) line level
  logic rx_meta, rx_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_line;
      rx_sync <= rx_meta;
    end
  end

  state_t                rx_st;
  logic [OS_W-1:0]       rx_os;
  logic [BIT_W-1:0]      rx_bit;
  logic [FRAME_BITS-1:0] rx_shift;
  logic [FRAME_BITS-1:0] rx_shift_in;
  logic                  parity_ok;

  // New bits enter at the MSB so the first (LSB) bit ends up in bit 0
  assign rx_shift_in = (rx_shift >> 1) | (FRAME_BITS'(rx_sync) << (FRAME_BITS - 1));

`ifdef UART_PARITY_EN
  assign parity_ok = ~^rx_shift;
`else
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_st        <= IDLE;
      rx_os        <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      data_out     <= '0;
      rx_done      <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_done      <= 1'b0;
      rx_frame_err <= 1'b0;
      case (rx_st)
        IDLE: begin
          if (!rx_sync) begin
            rx_os <= '0;
            rx_st <= START;
          end
        end
        START: begin
          if (tick) begin
            if (rx_os == OS_HALF) begin
              rx_os  <= '0;
              rx_bit <= '0;
              rx_st  <= rx_sync ? IDLE : DATA;
            end else begin
              rx_os <= rx_os + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (rx_os == OS_LAST) begin
              rx_os    <= '0;
              rx_shift <= rx_shift_in;
              if (rx_bit == BIT_LAST) rx_st <= STOP;
              else                    rx_bit <= rx_bit + 1'b1;
            end else begin
              rx_os <= rx_os + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (rx_os == OS_LAST) begin
              rx_os <= '0;
              rx_st <= IDLE;
              if (rx_sync && parity_ok) begin
                data_out <= rx_shift[DATA_SIZE-1:0];
                rx_done  <= 1'b1;
              end else begin
                rx_frame_err <= 1'b1;
              end
            end else begin
              rx_os <= rx_os + 1'b1;
            end
          end
        end
        default: rx_st <= IDLE;
      endcase
    end
  end

  assign tx_state = tx_st;
  assign rx_state = rx_st;

endmodule

// File: tb/tb_uart.sv
// Directed bench for uart: loopback frames, external RX frames, glitch rejection, mid-frame reset.
// Honours UART_PARITY_EN so the same bench covers the parity build.
module tb_uart;

  localparam int DW  = 7;
  localparam int BIT = 48;
`ifdef UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB = DW + 2 + PB;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          tx_start = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          tx_line;
  logic          rx_line;
  logic [DW-1:0] data_out;
  logic          tx_busy;
  logic          rx_done;
  logic          rx_frame_err;
  logic [1:0]    tx_state;
  logic [1:0]    rx_state;
  logic          loop = 1'b1;
  logic          rx_drive = 1'b1;

  int total = 0;
  int bad   = 0;
  int d_n, e_n;
  logic [10:0] f;

  always #5 clk = ~clk;

  assign rx_line = loop ? tx_line : rx_drive;

  uart #(
    .DATA_SIZE(DW),
    .CLK_FREQ_HZ(50_000_000),
    .BAUD_RATE(960000),
    .OVERSAMPLE(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .TX_START(tx_start),
    .data_in(data_in),
    .tx_line(tx_line),
    .rx_line(rx_line),
    .data_out(data_out),
    .tx_busy(tx_busy),
    .rx_done(rx_done),
    .rx_frame_err(rx_frame_err),
    .tx_state(tx_state),
    .rx_state(rx_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Line levels of a whole frame, bit 0 = start bit
  function automatic logic [10:0] frame_bits(input logic [DW-1:0] d);
    logic [10:0] r;
    r = '0;
    r[DW:1] = d;
`ifdef UART_PARITY_EN
    r[DW+1] = ^d;
`endif
    r[NB-1] = 1'b1;
    return r;
  endfunction

  // Sends one word in loopback and checks every bit slot, busy length and reception
  task automatic tx_frame(input string tag, input logic [DW-1:0] d, input int ignore_at);
    logic [10:0] fb;
    int err_bits[11];
    int idle_err, busy_n, done_n, ferr_n;
    fb = frame_bits(d);
    foreach (err_bits[i]) err_bits[i] = 0;
    idle_err = 0; busy_n = 0; done_n = 0; ferr_n = 0;
    @(negedge clk);
    tx_start = 1'b1;
    data_in  = d;
    @(negedge clk);
    tx_start = 1'b0;
    data_in  = '0;
    for (int c = 0; c < 520; c++) begin
      if (c < NB * BIT) begin
        if (tx_line !== fb[c / BIT]) err_bits[c / BIT]++;
      end else if (tx_line !== 1'b1) begin
        idle_err++;
      end
      if (tx_busy) busy_n++;
      if (rx_done) done_n++;
      if (rx_frame_err) ferr_n++;
      if (c == ignore_at) tx_start = 1'b1;
      else if (c == ignore_at + 1) tx_start = 1'b0;
      @(negedge clk);
    end
    for (int b = 0; b < NB; b++) check($sformatf("%s_bit%0d", tag, b), err_bits[b], 0);
    check({tag, "_idle"}, idle_err, 0);
    check({tag, "_busy_len"}, busy_n, NB * BIT);
    check({tag, "_rx_done"}, done_n, 1);
    check({tag, "_rx_err"}, ferr_n, 0);
    check({tag, "_data_out"}, data_out, d);
  endtask

  // Drives a frame on rx_line; the last bit slot lasts stop_len clocks
  task automatic rx_frame(input logic [10:0] fb, input int stop_len, output int dn, output int en);
    int len;
    dn = 0; en = 0;
    for (int b = 0; b < NB + 1; b++) begin
      len = (b == NB - 1) ? stop_len : (b == NB) ? 100 : BIT;
      rx_drive = (b == NB) ? 1'b1 : fb[b];
      for (int k = 0; k < len; k++) begin
        @(negedge clk);
        if (rx_done) dn++;
        if (rx_frame_err) en++;
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_tx_line", tx_line, 1);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_data_out", data_out, 0);
    check("rst_rx_done", rx_done, 0);
    check("rst_rx_err", rx_frame_err, 0);
    check("rst_tx_state", tx_state, 0);
    check("rst_rx_state", rx_state, 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Loopback 7'h57 with an ignored request (data 0) during the DATA phase
    tx_frame("lb57", 7'h57, 60);

    loop = 1'b0;
    repeat (10) @(negedge clk);
    rx_frame(frame_bits(7'h2A), BIT, d_n, e_n);
    check("rx2a_done", d_n, 1);
    check("rx2a_err", e_n, 0);
    check("rx2a_data", data_out, 7'h2A);

    // Stop bit held low only 36 clocks so the trailing edge cannot look like a new start
    f = frame_bits(7'h55);
    f[NB-1] = 1'b0;
    rx_frame(f, 36, d_n, e_n);
    check("badstop_done", d_n, 0);
    check("badstop_err", e_n, 1);
    check("badstop_data", data_out, 7'h2A);

    d_n = 0; e_n = 0;
    rx_drive = 1'b0;
    repeat (6) @(negedge clk);
    rx_drive = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rx_done) d_n++;
      if (rx_frame_err) e_n++;
    end
    check("glitch_done", d_n, 0);
    check("glitch_err", e_n, 0);
    check("glitch_rx_state", rx_state, 0);

`ifdef UART_PARITY_EN
    f = frame_bits(7'h57);
    f[DW+1] = ~f[DW+1];
    rx_frame(f, BIT, d_n, e_n);
    check("parflip_done", d_n, 0);
    check("parflip_err", e_n, 1);
    check("parflip_data", data_out, 7'h2A);
`endif

    // Reset in the middle of bit 0 of 7'h3C (line low there)
    loop = 1'b1;
    repeat (10) @(negedge clk);
    tx_start = 1'b1;
    data_in  = 7'h3C;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (60) @(negedge clk);
    check("pre_rst_line", tx_line, 0);
    check("pre_rst_busy", tx_busy, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_line", tx_line, 1);
    check("mid_rst_busy", tx_busy, 0);
    check("mid_rst_tx_state", tx_state, 0);
    check("mid_rst_data_out", data_out, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    tx_frame("lb19", 7'h19, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
